// File: rtl/euler_interpolator_if.sv
// rtl/euler_interpolator_if.sv - handshake and solver RAM port bundle for the Euler interpolator
interface euler_interpolator_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 13
);
  logic                     Interpolate_Enable;
  logic                     Interpolate_DONE;
  logic                     ERR;
  logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD1;
  logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD2;
  logic [DATA_WIDTH-1:0]    RAM_DATA_RD1;
  logic [DATA_WIDTH-1:0]    RAM_DATA_RD2;
  logic [ADDRESS_WIDTH-1:0] RAM_ADD_WR;
  logic [DATA_WIDTH-1:0]    RAM_DATA_WR;
  logic                     RAM_ENABLE_WR;

  // interpolator side: drives addresses, write port and handshake acknowledge
  modport master (
    input  Interpolate_Enable, RAM_DATA_RD1, RAM_DATA_RD2,
    output Interpolate_DONE, ERR, RAM_ADD_RD1, RAM_ADD_RD2,
           RAM_ADD_WR, RAM_DATA_WR, RAM_ENABLE_WR
  );

  // solver/RAM side
  modport slave (
    output Interpolate_Enable, RAM_DATA_RD1, RAM_DATA_RD2,
    input  Interpolate_DONE, ERR, RAM_ADD_RD1, RAM_ADD_RD2,
           RAM_ADD_WR, RAM_DATA_WR, RAM_ENABLE_WR
  );
endinterface

// File: rtl/euler_interpolator.sv
// rtl/euler_interpolator.sv - linear interpolation of two stored solution vectors to a target time
module euler_interpolator #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 13,
  parameter int FRAC_BITS     = 32,
  parameter int MAX_N         = 1024,
  parameter int T0_ADDR       = 0,
  parameter int T1_ADDR       = 1,
  parameter int TK_ADDR       = 2,
  parameter int N_ADDR        = 3,
  parameter int U0_BASE       = 16,
  parameter int U1_BASE       = 2048,
  parameter int OUT_BASE      = 4096
) (
  input logic                  CLK,
  input logic                  RST_N,
  euler_interpolator_if.master bus
);
  localparam int CW = $clog2(MAX_N + 1);
  localparam int BW = $clog2(FRAC_BITS + 1);
  localparam int WW = DATA_WIDTH + 1;
  localparam int RW = DATA_WIDTH + 2;
  localparam int PW = WW + FRAC_BITS + 2;
  localparam int AW = ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_T, S_LD_TK, S_DIV, S_ELEM_RD, S_ELEM_WR, S_FIN
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] t0, t1;
  logic [CW-1:0]         n, idx;
  logic [FRAC_BITS:0]    ratio;
  logic [RW-1:0]         rem, den_q;
  logic [BW-1:0]         bit_cnt;
  logic                  done, err, wr_en;
  logic [AW-1:0]         rd1, rd2, wr_add;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  assign rd_a = bus.RAM_DATA_RD1;
  assign rd_b = bus.RAM_DATA_RD2;

  // Scalars seen in LD_TK: rd_a carries Tk, rd_b carries the N word.
  // Differences are one bit wider so Tk-T0 and T1-T0 never overflow.
  logic signed [WW-1:0] num, den;
  logic [15:0]          n_word;
  logic [CW-1:0]        n_sat;
  logic                 den_bad, num_low, num_high;
  assign num      = {rd_a[DATA_WIDTH-1], rd_a} - {t0[DATA_WIDTH-1], t0};
  assign den      = {t1[DATA_WIDTH-1], t1} - {t0[DATA_WIDTH-1], t0};
  assign n_word   = rd_b[15:0];
  assign n_sat    = (n_word > 16'(MAX_N)) ? CW'(MAX_N) : CW'(n_word);
  assign den_bad  = den[WW-1] || (den == '0);
  assign num_low  = num[WW-1] || (num == '0);
  assign num_high = (num >= den);

  // Restoring divider step; remainder stays below den so one extra bit covers the shift.
  logic [RW-1:0] rem_sh, rem_nx;
  logic          q_bit;
  assign rem_sh = {rem[RW-2:0], 1'b0};
  assign q_bit  = (rem_sh >= den_q);
  assign rem_nx = q_bit ? (rem_sh - den_q) : rem_sh;

  // Element datapath in ELEM_RD: rd_a = U0[i], rd_b = U1[i]; taking the product
  // slice above FRAC_BITS is the flooring arithmetic shift, the add wraps.
  logic signed [WW-1:0]          diff;
  logic signed [FRAC_BITS+1:0]   ratio_s;
  logic signed [PW-1:0]          prod;
  logic [DATA_WIDTH-1:0]         elem_out;
  logic [CW-1:0]                 idx_nx;
  assign diff     = {rd_b[DATA_WIDTH-1], rd_b} - {rd_a[DATA_WIDTH-1], rd_a};
  assign ratio_s  = {1'b0, ratio};
  assign prod     = PW'(diff) * PW'(ratio_s);
  assign elem_out = rd_a + prod[FRAC_BITS +: DATA_WIDTH];
  assign idx_nx   = idx + CW'(1);

  logic unused_bits;
  assign unused_bits = ^{rem[RW-1], prod[FRAC_BITS-1:0], prod[PW-1:FRAC_BITS+DATA_WIDTH]};

  // Job sequencer: scalar loads, ratio resolution, divider, then a read/write pair per element
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      t0      <= '0;
      t1      <= '0;
      n       <= '0;
      idx     <= '0;
      ratio   <= '0;
      rem     <= '0;
      den_q   <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      wr_en   <= 1'b0;
      rd1     <= '0;
      rd2     <= '0;
      wr_add  <= '0;
      wr_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Interpolate_Enable) begin
            err   <= 1'b0;
            rd1   <= AW'(T0_ADDR);
            rd2   <= AW'(T1_ADDR);
            state <= S_LD_T;
          end
        end
        S_LD_T: begin
          t0    <= rd_a;
          t1    <= rd_b;
          rd1   <= AW'(TK_ADDR);
          rd2   <= AW'(N_ADDR);
          state <= S_LD_TK;
        end
        S_LD_TK: begin
          n       <= n_sat;
          idx     <= '0;
          bit_cnt <= '0;
          rem     <= {1'b0, num};
          den_q   <= {1'b0, den};
          if (den_bad || num_low || num_high) begin
            ratio <= (den_bad || num_low) ? '0 : {1'b1, {FRAC_BITS{1'b0}}};
            err   <= den_bad;
            if (n_sat == '0) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              rd1   <= AW'(U0_BASE);
              rd2   <= AW'(U1_BASE);
              state <= S_ELEM_RD;
            end
          end else begin
            ratio <= '0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          rem     <= rem_nx;
          ratio   <= {ratio[FRAC_BITS-1:0], q_bit};
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == BW'(FRAC_BITS - 1)) begin
            if (n == '0) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              rd1   <= AW'(U0_BASE);
              rd2   <= AW'(U1_BASE);
              state <= S_ELEM_RD;
            end
          end
        end
        S_ELEM_RD: begin
          wr_data <= elem_out;
          wr_add  <= AW'(OUT_BASE) + AW'(idx);
          wr_en   <= 1'b1;
          state   <= S_ELEM_WR;
        end
        S_ELEM_WR: begin
          wr_en <= 1'b0;
          if (idx_nx == n) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            idx   <= idx_nx;
            rd1   <= AW'(U0_BASE) + AW'(idx_nx);
            rd2   <= AW'(U1_BASE) + AW'(idx_nx);
            state <= S_ELEM_RD;
          end
        end
        S_FIN: begin
          if (!bus.Interpolate_Enable) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Interpolate_DONE = done;
  assign bus.ERR              = err;
  assign bus.RAM_ADD_RD1      = rd1;
  assign bus.RAM_ADD_RD2      = rd2;
  assign bus.RAM_ADD_WR       = wr_add;
  assign bus.RAM_DATA_WR      = wr_data;
  assign bus.RAM_ENABLE_WR    = wr_en;
endmodule

// File: tb/tb_euler_interpolator.sv
// tb/tb_euler_interpolator.sv - self-checking bench for euler_interpolator against an arithmetic model
module tb_euler_interpolator;
  localparam int DW = 64;
  localparam int AW = 13;
  localparam int F  = 32;
  localparam int MAX_N = 1024;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  euler_interpolator_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  euler_interpolator #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FRAC_BITS(F), .MAX_N(MAX_N)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  logic [DW-1:0] in_mem  [0:(1<<AW)-1];
  logic [DW-1:0] out_mem [0:(1<<AW)-1];
  assign bus.RAM_DATA_RD1 = in_mem[bus.RAM_ADD_RD1];
  assign bus.RAM_DATA_RD2 = in_mem[bus.RAM_ADD_RD2];
  always @(posedge CLK) if (bus.RAM_ENABLE_WR) out_mem[bus.RAM_ADD_WR] <= bus.RAM_DATA_WR;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  logic [AW-1:0] last_wr;
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ratio = clamp((Tk-T0)/(T1-T0), 0, 1) in Q.F, truncated
  function automatic logic [32:0] model_ratio(input logic signed [63:0] t0, t1, tk,
                                              output bit err, output bit divp);
    logic signed [127:0] a, b, c, num, den;
    a = t0; b = t1; c = tk;
    num = c - a;
    den = b - a;
    err = (den <= 0);
    divp = 1'b0;
    if (den <= 0 || num <= 0) return 33'd0;
    if (num >= den) return 33'h1_0000_0000;
    divp = 1'b1;
    return 33'((num <<< F) / den);
  endfunction

  function automatic logic [63:0] model_elem(input logic signed [63:0] u0, u1, input logic [32:0] r);
    logic signed [127:0] a, b, rr, p;
    a = u0; b = u1;
    rr = {95'd0, r};
    p = (b - a) * rr;
    p = p >>> F;
    return u0 + p[63:0];
  endfunction

  task automatic set_job(input logic [63:0] t0, t1, tk, nw, input int seed);
    in_mem[0] = t0; in_mem[1] = t1; in_mem[2] = tk; in_mem[3] = nw;
    for (int i = 0; i < MAX_N; i++) begin
      in_mem[16 + i]   = (64'(i) * 64'h0000_0002_7E3A_1C05) ^ (64'(seed) << 40);
      in_mem[2048 + i] = 64'(i + seed) * 64'hFFFF_FFF3_1D2B_4A67;
    end
  endtask

  task automatic prep_job(output int lat, output bit e, output int n);
    logic [32:0] r;
    bit d;
    n = int'(in_mem[3][15:0]);
    if (n > MAX_N) n = MAX_N;
    r = model_ratio(in_mem[0], in_mem[1], in_mem[2], e, d);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(AW'(4096 + i));
      exp_data.push_back(model_elem(in_mem[16 + i], in_mem[2048 + i], r));
    end
    lat = 2 + (d ? F : 0) + 2 * n;
  endtask

  // one clock, sampled 1 time unit after the edge; every write strobe is checked here
  task automatic sample_cycle();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(posedge CLK);
    #1;
    if (bus.RAM_ENABLE_WR) begin
      wr_count++;
      last_wr = bus.RAM_ADD_WR;
      if (exp_addr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %h data %h, required no write", bus.RAM_ADD_WR, bus.RAM_DATA_WR);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check("wr_addr", 64'(bus.RAM_ADD_WR), 64'(ea));
        check("wr_data", bus.RAM_DATA_WR, ed);
      end
    end
  endtask

  task automatic run_job(input string tag, input int drop_at, input int hold, output int lat);
    int exp_lat, n, cyc;
    bit exp_err;
    prep_job(exp_lat, exp_err, n);
    wr_count = 0;
    @(negedge CLK);
    bus.Interpolate_Enable = 1'b1;
    @(posedge CLK);
    cyc = 0;
    do begin
      sample_cycle();
      cyc++;
      if (cyc == drop_at) bus.Interpolate_Enable = 1'b0;
    end while (!bus.Interpolate_DONE && cyc < exp_lat + 64);
    lat = cyc;
    check({tag, "_done"}, 64'(bus.Interpolate_DONE), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_err"}, 64'(bus.ERR), 64'(exp_err));
    check({tag, "_writes"}, 64'(wr_count), 64'(n));
    check({tag, "_left"}, 64'(exp_addr.size()), 64'd0);
    if (bus.Interpolate_Enable) begin
      for (int k = 0; k < hold; k++) begin
        sample_cycle();
        check({tag, "_done_hold"}, 64'(bus.Interpolate_DONE), 64'd1);
      end
      bus.Interpolate_Enable = 1'b0;
      sample_cycle();
      check({tag, "_done_fall"}, 64'(bus.Interpolate_DONE), 64'd0);
    end else begin
      sample_cycle();
      check({tag, "_done_pulse"}, 64'(bus.Interpolate_DONE), 64'd0);
    end
    check({tag, "_writes_after"}, 64'(wr_count), 64'(n));
  endtask

  task automatic set_basic();
    set_job(64'd0, 64'h1_0000_0000, 64'h4000_0000, 64'd2, 1);
    in_mem[16]   = 64'h2_0000_0000;
    in_mem[17]   = 64'hFFFF_FFFC_0000_0000;
    in_mem[2048] = 64'h6_0000_0000;
    in_mem[2049] = 64'h4_0000_0000;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_e, n_e;
    bit err_e, d;
    logic [32:0] r;

    for (int i = 0; i < (1 << AW); i++) in_mem[i] = '0;
    RST_N = 1'b0;
    bus.Interpolate_Enable = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_done", 64'(bus.Interpolate_DONE), 64'd0);
    check("rst_err", 64'(bus.ERR), 64'd0);
    check("rst_wr_en", 64'(bus.RAM_ENABLE_WR), 64'd0);
    check("rst_rd1", 64'(bus.RAM_ADD_RD1), 64'd0);
    check("rst_rd2", 64'(bus.RAM_ADD_RD2), 64'd0);
    check("rst_wr_add", 64'(bus.RAM_ADD_WR), 64'd0);
    check("rst_wr_data", bus.RAM_DATA_WR, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    r = model_ratio(64'h1_0000_0000, 64'h4_0000_0000, 64'h2_0000_0000, err_e, d);
    check("model_ratio_third", 64'(r), 64'h5555_5555);
    check("model_elem_basic", model_elem(64'hFFFF_FFFC_0000_0000, 64'h4_0000_0000, 33'h4000_0000),
          64'hFFFF_FFFE_0000_0000);

    set_basic();
    run_job("basic", -1, 3, lat);
    check("basic_lat38", 64'(lat), 64'd38);
    check("basic_out0", out_mem[4096], 64'h3_0000_0000);
    check("basic_out1", out_mem[4097], 64'hFFFF_FFFE_0000_0000);

    set_job(64'h1_0000_0000, 64'h3_0000_0000, 64'h3_0000_0000, 64'h1234_0000_0000_0003, 2);
    run_job("tk_eq_t1", -1, 1, lat);
    check("tk_eq_t1_lat", 64'(lat), 64'd8);
    for (int i = 0; i < 3; i++) check("tk_eq_t1_out", out_mem[4096 + i], in_mem[2048 + i]);

    set_job(64'h5_0000_0000, 64'hA_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'd4, 3);
    run_job("tk_lt_t0", -1, 0, lat);
    check("tk_lt_t0_lat", 64'(lat), 64'd10);
    for (int i = 0; i < 4; i++) check("tk_lt_t0_out", out_mem[4096 + i], in_mem[16 + i]);

    set_job(64'h7_0000_0000, 64'h7_0000_0000, 64'h8_0000_0000, 64'd3, 4);
    run_job("degen", -1, 0, lat);
    check("degen_err", 64'(bus.ERR), 64'd1);
    for (int i = 0; i < 3; i++) check("degen_out", out_mem[4096 + i], in_mem[16 + i]);

    set_job(64'h1_0000_0000, 64'h4_0000_0000, 64'h2_0000_0000, 64'd5, 5);
    run_job("third_drop", 5, 0, lat);
    check("third_lat", 64'(lat), 64'd44);
    check("err_cleared", 64'(bus.ERR), 64'd0);

    set_job(64'd0, 64'h4_0000_0000, 64'h1_0000_0000, 64'd0, 6);
    run_job("n_zero", -1, 0, lat);
    check("n_zero_lat", 64'(lat), 64'd34);
    check("n_zero_writes", 64'(wr_count), 64'd0);

    set_job(64'd0, 64'h1_0000_0000, 64'h8000_0000, 64'h0000_0000_0000_FFFF, 7);
    run_job("n_max", -1, 0, lat);
    check("n_max_lat", 64'(lat), 64'd2082);
    check("n_max_writes", 64'(wr_count), 64'd1024);
    check("n_max_last", 64'(last_wr), 64'(4096 + 1023));

    set_job(64'd0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd8, 9);
    prep_job(lat_e, err_e, n_e);
    wr_count = 0;
    @(negedge CLK);
    bus.Interpolate_Enable = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 12; c++) sample_cycle();
    check("rst_mid_rd1", 64'(bus.RAM_ADD_RD1), 64'(16 + 5));
    RST_N = 1'b0;
    sample_cycle();
    check("rst_mid_done", 64'(bus.Interpolate_DONE), 64'd0);
    check("rst_mid_wr_en", 64'(bus.RAM_ENABLE_WR), 64'd0);
    check("rst_mid_rd1_zero", 64'(bus.RAM_ADD_RD1), 64'd0);
    check("rst_mid_writes", 64'(wr_count), 64'd5);
    RST_N = 1'b1;
    bus.Interpolate_Enable = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    sample_cycle();

    set_basic();
    run_job("after_rst", -1, 0, lat);
    check("after_rst_lat", 64'(lat), 64'd38);
    check("after_rst_out0", out_mem[4096], 64'h3_0000_0000);
    check("after_rst_out1", out_mem[4097], 64'hFFFF_FFFE_0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
